// File: rtl/divider_4_pkg.sv
// Shared definitions for the divider_4 sign-magnitude divider:
// default widths, FSM state encoding, iteration counter width and
// sign-magnitude field positions.
package divider_4_pkg;

    // Default dividend magnitude width and divisor/quotient/remainder magnitude width
    localparam int NW_DEF = 16;
    localparam int DW_DEF = 8;

    // Iteration counter width: counts 0 .. NW-1
    localparam int CNT_W = $clog2(NW_DEF);

    // Sign bit positions in the sign-magnitude operand words
    localparam int NUM_SIGN = NW_DEF;
    localparam int DEN_SIGN = DW_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step_4.sv
// One restoring division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step_4
#(
    parameter int DW = 8
) (
    input  logic [DW:0]   rem_in,
    input  logic          bit_in,
    input  logic [DW-1:0] dsr,
    output logic [DW:0]   rem_out,
    output logic          q_bit
);

    logic [DW+1:0] shifted;
    logic [DW+1:0] dsr_w;

    // Shift, compare and conditionally subtract
    always_comb begin
        shifted = {rem_in, bit_in};
        dsr_w   = {2'b00, dsr};
        q_bit   = (shifted >= dsr_w);
        rem_out = (DW+1)'(q_bit ? (shifted - dsr_w) : shifted);
    end

endmodule

// File: rtl/divider_4.sv
// divider_4: sequential restoring sign-magnitude divider.
// 17-bit dividend / 9-bit divisor -> 9-bit quotient and remainder,
// one quotient bit per clock, fixed latency of NW+1 cycles.
// Optional build macro DIVIDER_4_ROUND_EN: round the quotient magnitude
// half up before saturation (remainder stays truncated).
module divider_4
    import divider_4_pkg::*;
#(
    parameter int NW = NW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW:0]   dividend,
    input  logic [DW:0]   divisor,
    output logic [DW:0]   quot,
    output logic [DW:0]   rem,
    output logic          rdy,
    output logic          busy,
    output logic          ovf,
    output logic          dz
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NW - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] count;

    // Datapath working registers (loaded at accept, no reset needed)
    logic [DW:0]      rem_acc;
    logic [NW-1:0]    quo;
    logic [DW-1:0]    dsr;
    logic             sign_q;
    logic             sign_r;

    logic [DW:0]      step_rem;
    logic             step_bit;
    logic [NW-1:0]    quo_fin;

    logic             accept;
    logic             last;

    logic [NW:0]      q_wide;
    logic [DW-1:0]    q_mag;
    logic [DW-1:0]    r_mag;
    logic             res_ovf;
    logic             res_dz;
    logic [DW:0]      res_quot;
    logic [DW:0]      res_rem;

    // Clamp a wide quotient magnitude to DW bits; MSB of the result is the overflow flag
    function automatic logic [DW:0] sat_mag(input logic [NW:0] q);
        if (|q[NW:DW])
            return {1'b1, {DW{1'b1}}};
        return {1'b0, q[DW-1:0]};
    endfunction

`ifdef DIVIDER_4_ROUND_EN
    // Round half up on magnitude: bump the quotient when 2*rem >= divisor
    function automatic logic [NW:0] round_mag(input logic [NW-1:0] q,
                                              input logic [DW-1:0] r,
                                              input logic [DW-1:0] d);
        logic inc;
        inc = ({r, 1'b0} >= {1'b0, d});
        return {1'b0, q} + {{NW{1'b0}}, inc};
    endfunction
`endif

    div_step_4 #(.DW(DW)) u_step (
        .rem_in  (rem_acc),
        .bit_in  (quo[NW-1]),
        .dsr     (dsr),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    assign accept  = (state == IDLE) && start;
    assign last    = (state == CALC) && (count == LAST);
    assign quo_fin = {quo[NW-2:0], step_bit};

    // FSM next state and status outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        rdy      = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (count == LAST)
                    state_nx = DONE;
            end
            DONE: begin
                rdy      = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM state and iteration counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nx;
            if (accept)
                count <= '0;
            else if (state == CALC)
                count <= count + 1'b1;
        end
    end

    // Operand capture and shift-subtract iteration
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_acc <= '0;
            quo     <= dividend[NW-1:0];
            dsr     <= divisor[DW-1:0];
            sign_q  <= dividend[NW] ^ divisor[DW];
            sign_r  <= dividend[NW];
        end else if (state == CALC) begin
            rem_acc <= step_rem;
            quo     <= quo_fin;
        end
    end

    // Final result formatting from the last iteration's step outputs
    always_comb begin
`ifdef DIVIDER_4_ROUND_EN
        q_wide = round_mag(quo_fin, step_rem[DW-1:0], dsr);
`else
        q_wide = {1'b0, quo_fin};
`endif
        {res_ovf, q_mag} = sat_mag(q_wide);
        r_mag  = step_rem[DW-1:0];
        res_dz = (dsr == '0);
        if (res_dz) begin
            q_mag   = '1;
            res_ovf = 1'b0;
            r_mag   = '0;
        end
        res_quot = {sign_q & (q_mag != '0), q_mag};
        res_rem  = {sign_r & (r_mag != '0), r_mag};
    end

    // Result registers: loaded as the FSM enters DONE, held until the next result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot <= '0;
            rem  <= '0;
            ovf  <= 1'b0;
            dz   <= 1'b0;
        end else if (last) begin
            quot <= res_quot;
            rem  <= res_rem;
            ovf  <= res_ovf;
            dz   <= res_dz;
        end
    end

endmodule

// File: tb/tb_divider_4.sv
// Self-checking bench for divider_4: directed cases plus randomized
// operands compared against an integer reference model.
module tb_divider_4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [16:0] dividend;
    logic [8:0]  divisor;
    logic [8:0]  quot;
    logic [8:0]  rem;
    logic        rdy;
    logic        busy;
    logic        ovf;
    logic        dz;

    int n_chk  = 0;
    int n_pass = 0;

    divider_4 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quot     (quot),
        .rem      (rem),
        .rdy      (rdy),
        .busy     (busy),
        .ovf      (ovf),
        .dz       (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference: plain integer division on the sign-magnitude fields
    task automatic model(input logic [16:0] a, input logic [8:0] b,
                         output logic [8:0] eq, output logic [8:0] er,
                         output logic eovf, output logic edz);
        int nm, dm, q, r, qm, rm;
        nm   = int'(a[15:0]);
        dm   = int'(b[7:0]);
        eovf = 1'b0;
        edz  = 1'b0;
        if (dm == 0) begin
            edz = 1'b1;
            qm  = 255;
            rm  = 0;
        end else begin
            q = nm / dm;
            r = nm % dm;
`ifdef DIVIDER_4_ROUND_EN
            if (2 * r >= dm) q = q + 1;
`endif
            if (q > 255) begin
                qm   = 255;
                eovf = 1'b1;
            end else begin
                qm = q;
            end
            rm = r;
        end
        eq = {(a[16] ^ b[8]) && (qm != 0), 8'(qm)};
        er = {a[16] && (rm != 0), 8'(rm)};
    endtask

    // One full division; optionally pokes start during cycle 3 and the rdy cycle
    task automatic run_op(input string tag, input logic [16:0] a, input logic [8:0] b, input bit poke);
        logic [8:0] eq, er;
        logic       eovf, edz;
        logic [8:0] gq, gr;
        logic       govf, gdz;
        int         first_rdy;
        int         bad_busy;
        logic       rdy_after;
        model(a, b, eq, er, eovf, edz);
        first_rdy = -1;
        bad_busy  = 0;
        rdy_after = 1'b0;
        gq = '0; gr = '0; govf = 1'b0; gdz = 1'b0;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 18; c++) begin
            if (rdy === 1'b1 && first_rdy < 0) first_rdy = c;
            if (c <= 16 && busy !== 1'b1) bad_busy++;
            if (c >= 17 && busy !== 1'b0) bad_busy++;
            if (c == 17) begin
                gq = quot; gr = rem; govf = ovf; gdz = dz;
            end
            if (c == 18) rdy_after = rdy;
            start    = poke && (c == 3 || c == 17);
            dividend = 17'($urandom);
            divisor  = 9'($urandom);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check({tag, ".latency"}, 32'(first_rdy), 32'd17);
        check({tag, ".busy"}, 32'(bad_busy), 32'd0);
        check({tag, ".rdy_pulse"}, {31'd0, rdy_after}, 32'd0);
        check({tag, ".quot"}, {23'd0, gq}, {23'd0, eq});
        check({tag, ".rem"}, {23'd0, gr}, {23'd0, er});
        check({tag, ".ovf"}, {31'd0, govf}, {31'd0, eovf});
        check({tag, ".dz"}, {31'd0, gdz}, {31'd0, edz});
        check({tag, ".hold"}, {12'd0, quot, rem, ovf, dz}, {12'd0, eq, er, eovf, edz});
    endtask

    initial begin
        logic [16:0] ra;
        logic [8:0]  rb;
        int          rdy_seen;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #3;
        check("reset.outputs", {10'd0, quot, rem, ovf, dz, rdy, busy}, 32'd0);
        #9;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle.busy", {31'd0, busy}, 32'd0);

        run_op("p1000_p7",   {1'b0, 16'd1000},  {1'b0, 8'd7}, 1'b0);
        run_op("n1000_p7",   {1'b1, 16'd1000},  {1'b0, 8'd7}, 1'b0);
        run_op("n3_n7",      {1'b1, 16'd3},     {1'b1, 8'd7}, 1'b0);
        run_op("p65535_p1",  {1'b0, 16'd65535}, {1'b0, 8'd1}, 1'b0);
        run_op("p510_p2",    {1'b0, 16'd510},   {1'b0, 8'd2}, 1'b0);
        run_op("p1234_n0",   {1'b0, 16'd1234},  {1'b1, 8'd0}, 1'b0);
        run_op("after_dz",   {1'b0, 16'd100},   {1'b0, 8'd9}, 1'b0);
        run_op("p511_p2",    {1'b0, 16'd511},   {1'b0, 8'd2}, 1'b0);
        run_op("p13_p2",     {1'b0, 16'd13},    {1'b0, 8'd2}, 1'b0);
        run_op("poke",       {1'b1, 16'd4321},  {1'b0, 8'd37}, 1'b1);

        // Reset in the middle of an operation
        @(negedge clk);
        dividend = {1'b1, 16'd5000};
        divisor  = {1'b0, 8'd3};
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("midreset.outputs", {10'd0, quot, rem, ovf, dz, rdy, busy}, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        rdy_seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (rdy === 1'b1) rdy_seen++;
        end
        check("midreset.no_rdy", 32'(rdy_seen), 32'd0);
        check("midreset.idle", {10'd0, quot, rem, ovf, dz, rdy, busy}, 32'd0);
        run_op("post_reset", {1'b0, 16'd777}, {1'b1, 8'd5}, 1'b0);

        // Randomized operands, biased toward small and zero divisors
        for (int i = 0; i < 40; i++) begin
            ra = 17'($urandom);
            case ($urandom_range(0, 3))
                0: rb = {1'($urandom), 8'd0};
                1: rb = {1'($urandom), 8'($urandom_range(1, 4))};
                default: rb = 9'($urandom);
            endcase
            if (i % 5 == 0) ra[15:0] = 16'($urandom_range(0, 300));
            run_op("rand", ra, rb, (i % 7 == 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
